// File: rtl/commit_pkg.sv
// Shared constants and FSM state type for the commit monitor.
package commit_pkg;

   localparam logic [6:0] TRAP_OPCODE  = 7'h6b;
   localparam logic [7:0] TIMEOUT_CODE = 8'hFF;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2,
      TOUT = 2'd3
   } cm_state_e;

endpackage

// File: rtl/commit_lane_mask.sv
// Accepted-lane mask for one retire group: in-order prefix of valid lanes,
// truncated after the oldest trap instruction.
module commit_lane_mask
   import commit_pkg::*;
#(
   parameter int unsigned COMMIT_WIDTH = 2,
   parameter int unsigned IDX_W        = 1,
   parameter int unsigned CNT_W        = 2
) (
   input  logic [COMMIT_WIDTH-1:0]   in_valid,
   input  logic [COMMIT_WIDTH*7-1:0] in_opcode,
   output logic [COMMIT_WIDTH-1:0]   acc_mask,
   output logic                      trap_hit,
   output logic [IDX_W-1:0]          trap_idx,
   output logic [CNT_W-1:0]          acc_cnt
);

   logic open_q;

   always_comb begin
      acc_mask = '0;
      trap_hit = 1'b0;
      trap_idx = '0;
      acc_cnt  = '0;
      open_q   = 1'b1;
      for (int i = 0; i < int'(COMMIT_WIDTH); i++) begin
         if (open_q && in_valid[i]) begin
            acc_mask[i] = 1'b1;
            acc_cnt     = acc_cnt + CNT_W'(1);
            // The trap lane itself commits; everything younger is dropped.
            if (in_opcode[i*7 +: 7] == TRAP_OPCODE) begin
               trap_hit = 1'b1;
               trap_idx = IDX_W'(i);
               open_q   = 1'b0;
            end
         end else begin
            open_q = 1'b0;
         end
      end
   end

endmodule

// File: rtl/commit_monitor.sv
// Multi-lane retirement monitor: registers accepted commits, tracks cycle and
// instruction counts, detects the trap instruction and runs a no-commit watchdog.
//
// state | meaning
// IDLE  | after reset, waiting for the first commit; watchdog inactive
// RUN   | committing; watchdog counts cycles without a commit
// HALT  | trap instruction retired; inputs ignored until reset
// TOUT  | watchdog expired; inputs ignored until reset
module commit_monitor
   import commit_pkg::*;
#(
   parameter int unsigned      COMMIT_WIDTH = 2,
   parameter int unsigned      XLEN         = 64,
   parameter logic [XLEN-1:0]  PC_START     = 'h8000_0000,
   parameter int unsigned      TIMEOUT      = 5000
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [COMMIT_WIDTH-1:0]      in_valid,
   input  logic [COMMIT_WIDTH*XLEN-1:0] in_pc,
   input  logic [COMMIT_WIDTH*32-1:0]   in_inst,
   input  logic [COMMIT_WIDTH-1:0]      in_wen,
   input  logic [COMMIT_WIDTH*5-1:0]    in_wdest,
   input  logic [COMMIT_WIDTH*XLEN-1:0] in_wdata,
   input  logic [COMMIT_WIDTH-1:0]      in_mmio,
   input  logic [7:0]                   trap_code_src,
   output logic [COMMIT_WIDTH-1:0]      cmt_valid,
   output logic [COMMIT_WIDTH*XLEN-1:0] cmt_pc,
   output logic [COMMIT_WIDTH*32-1:0]   cmt_inst,
   output logic [COMMIT_WIDTH-1:0]      cmt_wen,
   output logic [COMMIT_WIDTH*8-1:0]    cmt_wdest,
   output logic [COMMIT_WIDTH*XLEN-1:0] cmt_wdata,
   output logic [COMMIT_WIDTH-1:0]      cmt_skip,
   output logic                         trap_valid,
   output logic [7:0]                   trap_code,
   output logic [XLEN-1:0]              trap_pc,
   output logic [63:0]                  cycle_cnt,
   output logic [63:0]                  instr_cnt,
   output logic                         timeout
);

   localparam int unsigned IDX_W = (COMMIT_WIDTH > 1) ? $clog2(COMMIT_WIDTH) : 1;
   localparam int unsigned CNT_W = $clog2(COMMIT_WIDTH + 1);
   localparam int unsigned WD_W  = $clog2(TIMEOUT);

   cm_state_e state_q, state_d;

   logic [COMMIT_WIDTH*7-1:0] lane_op;
   logic [COMMIT_WIDTH-1:0]   mask_raw, acc;
   logic                      trap_hit, trap_take, any_acc, active, wd_expire;
   logic [IDX_W-1:0]          trap_idx;
   logic [CNT_W-1:0]          acc_cnt;
   logic [XLEN-1:0]           trap_pc_sel, last_pc_sel;

   logic [COMMIT_WIDTH-1:0]      cmt_valid_q, cmt_wen_q, cmt_skip_q;
   logic [COMMIT_WIDTH-1:0]      cmt_wen_d, cmt_skip_d;
   logic [COMMIT_WIDTH*XLEN-1:0] cmt_pc_q, cmt_pc_d, cmt_wdata_q, cmt_wdata_d;
   logic [COMMIT_WIDTH*32-1:0]   cmt_inst_q, cmt_inst_d;
   logic [COMMIT_WIDTH*8-1:0]    cmt_wdest_q, cmt_wdest_d;
   logic [63:0]                  cycle_q, instr_q;
   logic [WD_W-1:0]              wdog_q;
   logic [XLEN-1:0]              last_pc_q, trap_pc_q;
   logic [7:0]                   trap_code_q;

   always_comb begin
      lane_op = '0;
      for (int i = 0; i < int'(COMMIT_WIDTH); i++) begin
         lane_op[i*7 +: 7] = in_inst[i*32 +: 7];
      end
   end

   commit_lane_mask #(
      .COMMIT_WIDTH (COMMIT_WIDTH),
      .IDX_W        (IDX_W),
      .CNT_W        (CNT_W)
   ) u_lane_mask (
      .in_valid  (in_valid),
      .in_opcode (lane_op),
      .acc_mask  (mask_raw),
      .trap_hit  (trap_hit),
      .trap_idx  (trap_idx),
      .acc_cnt   (acc_cnt)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= IDLE;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (trap_take)    state_d = HALT;
            else if (any_acc) state_d = RUN;
         end
         RUN: begin
            if (trap_take)      state_d = HALT;
            else if (wd_expire) state_d = TOUT;
         end
         default: state_d = state_q;
      endcase
   end

   always_comb begin
      active     = (state_q == IDLE) || (state_q == RUN);
      trap_valid = (state_q == HALT) || (state_q == TOUT);
      timeout    = (state_q == TOUT);
   end

   assign acc       = active ? mask_raw : '0;
   assign any_acc   = |acc;
   assign trap_take = active && trap_hit;
   assign wd_expire = (state_q == RUN) && !any_acc && (wdog_q == WD_W'(TIMEOUT - 1));

   // Dropped lanes present all-zero fields so downstream never sees stale data.
   always_comb begin
      cmt_pc_d    = '0;
      cmt_inst_d  = '0;
      cmt_wen_d   = '0;
      cmt_wdest_d = '0;
      cmt_wdata_d = '0;
      cmt_skip_d  = '0;
      trap_pc_sel = '0;
      last_pc_sel = '0;
      for (int i = 0; i < int'(COMMIT_WIDTH); i++) begin
         if (IDX_W'(i) == trap_idx) trap_pc_sel = in_pc[i*XLEN +: XLEN];
         if (acc[i]) begin
            last_pc_sel               = in_pc[i*XLEN +: XLEN];
            cmt_pc_d[i*XLEN +: XLEN]    = in_pc[i*XLEN +: XLEN];
            cmt_inst_d[i*32 +: 32]      = in_inst[i*32 +: 32];
            cmt_wen_d[i]                = in_wen[i];
            cmt_wdest_d[i*8 +: 8]       = {3'b000, in_wdest[i*5 +: 5]};
            cmt_wdata_d[i*XLEN +: XLEN] = in_wdata[i*XLEN +: XLEN];
            cmt_skip_d[i]               = (in_pc[i*XLEN +: XLEN] == PC_START) | in_mmio[i];
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cmt_valid_q <= '0;
         cmt_pc_q    <= '0;
         cmt_inst_q  <= '0;
         cmt_wen_q   <= '0;
         cmt_wdest_q <= '0;
         cmt_wdata_q <= '0;
         cmt_skip_q  <= '0;
         cycle_q     <= '0;
         instr_q     <= '0;
         wdog_q      <= '0;
         last_pc_q   <= '0;
         trap_pc_q   <= '0;
         trap_code_q <= '0;
      end else begin
         cmt_valid_q <= acc;
         cmt_pc_q    <= cmt_pc_d;
         cmt_inst_q  <= cmt_inst_d;
         cmt_wen_q   <= cmt_wen_d;
         cmt_wdest_q <= cmt_wdest_d;
         cmt_wdata_q <= cmt_wdata_d;
         cmt_skip_q  <= cmt_skip_d;
         if (active) begin
            cycle_q <= cycle_q + 64'd1;
            instr_q <= instr_q + 64'(acc_cnt);
         end
         if (any_acc) last_pc_q <= last_pc_sel;
         if (any_acc || state_q != RUN) wdog_q <= '0;
         else                           wdog_q <= wdog_q + WD_W'(1);
         if (trap_take) begin
            trap_code_q <= trap_code_src;
            trap_pc_q   <= trap_pc_sel;
         end else if (wd_expire) begin
            trap_code_q <= TIMEOUT_CODE;
            trap_pc_q   <= last_pc_q;
         end
      end
   end

   assign cmt_valid = cmt_valid_q;
   assign cmt_pc    = cmt_pc_q;
   assign cmt_inst  = cmt_inst_q;
   assign cmt_wen   = cmt_wen_q;
   assign cmt_wdest = cmt_wdest_q;
   assign cmt_wdata = cmt_wdata_q;
   assign cmt_skip  = cmt_skip_q;
   assign cycle_cnt = cycle_q;
   assign instr_cnt = instr_q;
   assign trap_code = trap_code_q;
   assign trap_pc   = trap_pc_q;

endmodule

// File: tb/tb_commit_monitor.sv
// Scoreboard bench for commit_monitor (2 lanes, XLEN 64, TIMEOUT 16).
module tb_commit_monitor;
   import commit_pkg::*;

   localparam int TO = 16;
   localparam logic [31:0] NOP  = 32'h0000_0013;
   localparam logic [31:0] TRAP = 32'h0000_006b;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic [1:0]   in_valid = '0, in_wen = '0, in_mmio = '0;
   logic [127:0] in_pc = '0, in_wdata = '0;
   logic [63:0]  in_inst = '0;
   logic [9:0]   in_wdest = '0;
   logic [7:0]   trap_code_src = '0;
   logic [1:0]   cmt_valid, cmt_wen, cmt_skip;
   logic [127:0] cmt_pc, cmt_wdata;
   logic [63:0]  cmt_inst;
   logic [15:0]  cmt_wdest;
   logic         trap_valid, timeout;
   logic [7:0]   trap_code;
   logic [63:0]  trap_pc, cycle_cnt, instr_cnt;

   typedef struct {
      logic [1:0]  valid;
      logic [1:0]  skip;
      logic [63:0] pc0, pc1, instr, cycle, tpc;
      logic        tv, to;
      logic [7:0]  code;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   int   checks = 0;
   int   failures = 0;

   int          m_st, m_wd;
   logic [63:0] m_instr, m_cycle, m_last, m_tpc;
   logic [7:0]  m_code;

   commit_monitor #(.COMMIT_WIDTH(2), .XLEN(64), .PC_START(64'h8000_0000), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_pc(in_pc), .in_inst(in_inst),
      .in_wen(in_wen), .in_wdest(in_wdest), .in_wdata(in_wdata), .in_mmio(in_mmio),
      .trap_code_src(trap_code_src), .cmt_valid(cmt_valid), .cmt_pc(cmt_pc),
      .cmt_inst(cmt_inst), .cmt_wen(cmt_wen), .cmt_wdest(cmt_wdest), .cmt_wdata(cmt_wdata),
      .cmt_skip(cmt_skip), .trap_valid(trap_valid), .trap_code(trap_code), .trap_pc(trap_pc),
      .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt), .timeout(timeout)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      m_st = 0; m_wd = 0; m_instr = '0; m_cycle = '0; m_last = '0; m_tpc = '0; m_code = '0;
      sb.delete();
   endtask

   // Drive one cycle of lane inputs, predict the registered result, clock once.
   task automatic step(input logic [1:0] v, input logic [63:0] p0, input logic [63:0] p1,
                       input logic [31:0] i0, input logic [31:0] i1,
                       input logic [1:0] mm, input logic [7:0] a0);
      exp_t x;
      logic [1:0]  acc;
      logic        hit, act;
      logic [63:0] hpc;
      in_valid = v; in_pc = {p1, p0}; in_inst = {i1, i0}; in_wen = v; in_mmio = mm;
      in_wdest = {p1[6:2], p0[6:2]}; in_wdata = {~p1, ~p0}; trap_code_src = a0;
      act = (m_st < 2);
      acc = 2'b00; hit = 1'b0; hpc = '0;
      if (act && v[0]) begin
         acc[0] = 1'b1;
         if (i0[6:0] == 7'h6b) begin hit = 1'b1; hpc = p0; end
      end
      if (act && v[0] && v[1] && !hit) begin
         acc[1] = 1'b1;
         if (i1[6:0] == 7'h6b) begin hit = 1'b1; hpc = p1; end
      end
      if (act) m_cycle = m_cycle + 64'd1;
      m_instr = m_instr + acc[0] + acc[1];
      if (hit) begin
         m_st = 2; m_code = a0; m_tpc = hpc;
      end else if (acc != 2'b00) begin
         m_st = 1; m_wd = 0; m_last = acc[1] ? p1 : p0;
      end else if (m_st == 1) begin
         if (m_wd == TO - 1) begin m_st = 3; m_code = 8'hFF; m_tpc = m_last; end
         else m_wd++;
      end
      x.valid = acc;
      x.skip  = {acc[1] & ((p1 == 64'h8000_0000) | mm[1]), acc[0] & ((p0 == 64'h8000_0000) | mm[0])};
      x.pc0   = acc[0] ? p0 : '0;
      x.pc1   = acc[1] ? p1 : '0;
      x.instr = m_instr; x.cycle = m_cycle;
      x.tv = (m_st >= 2); x.to = (m_st == 3); x.code = m_code; x.tpc = m_tpc;
      sb.push_back(x);
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      model_reset();
      in_valid = '0; in_mmio = '0;
      @(posedge clk); #1;
      rst = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (cmt_valid !== 2'b00) begin failures++; $display("FAIL reset_valid got=%b exp=00", cmt_valid); end
      checks++; if (cycle_cnt !== 64'd0 || instr_cnt !== 64'd0) begin failures++; $display("FAIL reset_cnt cyc=%0d ins=%0d exp=0/0", cycle_cnt, instr_cnt); end
      checks++; if (trap_valid !== 1'b0 || timeout !== 1'b0 || trap_code !== 8'h00) begin failures++; $display("FAIL reset_trap tv=%b to=%b code=%h exp=0/0/00", trap_valid, timeout, trap_code); end
   endtask

   task automatic test_dual_commit();
      step(2'b11, 64'h8000_0000, 64'h8000_0004, NOP, NOP, 2'b00, 8'h00);
      e = sb.pop_front();
      checks++; if (cmt_valid !== e.valid) begin failures++; $display("FAIL dual_valid got=%b exp=%b", cmt_valid, e.valid); end
      checks++; if (cmt_skip !== e.skip) begin failures++; $display("FAIL dual_skip got=%b exp=%b", cmt_skip, e.skip); end
      checks++; if (instr_cnt !== e.instr || cycle_cnt !== e.cycle) begin failures++; $display("FAIL dual_cnt ins=%0d cyc=%0d exp=%0d/%0d", instr_cnt, cycle_cnt, e.instr, e.cycle); end
      checks++; if (cmt_pc !== {e.pc1, e.pc0}) begin failures++; $display("FAIL dual_pc got=%h exp=%h", cmt_pc, {e.pc1, e.pc0}); end
      checks++; if (dut.state_q !== RUN) begin failures++; $display("FAIL dual_state got=%0d exp=%0d", dut.state_q, RUN); end
      checks++; if (cmt_wdest[15:8] !== 8'h01 || cmt_wdata[63:0] !== 64'hFFFF_FFFF_7FFF_FFFF || cmt_wen !== 2'b11) begin
         failures++; $display("FAIL dual_wb wdest=%h wdata=%h wen=%b", cmt_wdest, cmt_wdata[63:0], cmt_wen);
      end
   endtask

   task automatic test_hole();
      step(2'b10, 64'h8000_0008, 64'h8000_000c, NOP, NOP, 2'b00, 8'h00);
      e = sb.pop_front();
      checks++; if (cmt_valid !== e.valid) begin failures++; $display("FAIL hole_valid got=%b exp=%b", cmt_valid, e.valid); end
      checks++; if (instr_cnt !== e.instr) begin failures++; $display("FAIL hole_instr got=%0d exp=%0d", instr_cnt, e.instr); end
      checks++; if (cmt_pc !== 128'd0 || cmt_skip !== 2'b00) begin failures++; $display("FAIL hole_zero pc=%h skip=%b", cmt_pc, cmt_skip); end
   endtask

   task automatic test_mmio();
      step(2'b11, 64'h8000_0100, 64'hA000_0000, NOP, NOP, 2'b10, 8'h00);
      e = sb.pop_front();
      checks++; if (cmt_skip !== e.skip) begin failures++; $display("FAIL mmio_skip got=%b exp=%b", cmt_skip, e.skip); end
      checks++; if (instr_cnt !== e.instr) begin failures++; $display("FAIL mmio_instr got=%0d exp=%0d", instr_cnt, e.instr); end
   endtask

   task automatic test_reset_mid();
      step(2'b11, 64'h8000_0200, 64'h8000_0204, NOP, NOP, 2'b00, 8'h00);
      void'(sb.pop_front());
      in_valid = 2'b11;
      #2 rst = 1'b0;
      #1;
      checks++; if (cmt_valid !== 2'b00 || cmt_pc !== 128'd0 || cmt_skip !== 2'b00) begin failures++; $display("FAIL rstmid_cmt valid=%b pc=%h skip=%b exp=0", cmt_valid, cmt_pc, cmt_skip); end
      checks++; if (cycle_cnt !== 64'd0 || instr_cnt !== 64'd0) begin failures++; $display("FAIL rstmid_cnt cyc=%0d ins=%0d exp=0/0", cycle_cnt, instr_cnt); end
      model_reset();
      @(posedge clk); #1;
      rst = 1'b1;
      step(2'b00, 64'h0, 64'h0, NOP, NOP, 2'b00, 8'h00);
      e = sb.pop_front();
      checks++; if (cycle_cnt !== e.cycle || dut.state_q !== IDLE) begin failures++; $display("FAIL rstmid_restart cyc=%0d exp=%0d state=%0d", cycle_cnt, e.cycle, dut.state_q); end
   endtask

   task automatic test_timeout();
      do_reset();
      step(2'b01, 64'h8000_0010, 64'h0, NOP, NOP, 2'b00, 8'h00);
      void'(sb.pop_front());
      for (int k = 1; k <= TO; k++) begin
         step(2'b00, 64'h0, 64'h0, NOP, NOP, 2'b00, 8'h00);
         e = sb.pop_front();
         if (k == TO - 1 || k == TO) begin
            checks++; if (timeout !== e.to || trap_valid !== e.tv) begin failures++; $display("FAIL tout_flag idle=%0d to=%b tv=%b exp=%b/%b", k, timeout, trap_valid, e.to, e.tv); end
         end
      end
      checks++; if (trap_code !== e.code || trap_pc !== e.tpc) begin failures++; $display("FAIL tout_info code=%h pc=%h exp=%h/%h", trap_code, trap_pc, e.code, e.tpc); end
      for (int k = 0; k < 3; k++) begin
         step(2'b11, 64'h8000_0300, 64'h8000_0304, NOP, NOP, 2'b00, 8'h00);
         e = sb.pop_front();
      end
      checks++; if (cmt_valid !== e.valid || cycle_cnt !== e.cycle || instr_cnt !== e.instr) begin
         failures++; $display("FAIL tout_frozen valid=%b cyc=%0d ins=%0d exp=%b/%0d/%0d", cmt_valid, cycle_cnt, instr_cnt, e.valid, e.cycle, e.instr);
      end
   endtask

   task automatic test_trap_lane0();
      do_reset();
      step(2'b11, 64'h8000_0100, 64'h8000_0104, NOP, NOP, 2'b00, 8'h00);
      void'(sb.pop_front());
      step(2'b11, 64'h8000_0108, 64'h8000_010c, TRAP, NOP, 2'b00, 8'h00);
      e = sb.pop_front();
      checks++; if (cmt_valid !== e.valid || trap_valid !== e.tv) begin failures++; $display("FAIL trap0_valid valid=%b tv=%b exp=%b/%b", cmt_valid, trap_valid, e.valid, e.tv); end
      checks++; if (trap_code !== e.code || trap_pc !== e.tpc) begin failures++; $display("FAIL trap0_info code=%h pc=%h exp=%h/%h", trap_code, trap_pc, e.code, e.tpc); end
      checks++; if (instr_cnt !== e.instr || cmt_inst[63:32] !== 32'd0) begin failures++; $display("FAIL trap0_cnt ins=%0d inst1=%h exp=%0d/0", instr_cnt, cmt_inst[63:32], e.instr); end
      step(2'b11, 64'h8000_0110, 64'h8000_0114, NOP, NOP, 2'b00, 8'h33);
      e = sb.pop_front();
      checks++; if (cmt_valid !== e.valid || cycle_cnt !== e.cycle || instr_cnt !== e.instr || trap_code !== e.code) begin
         failures++; $display("FAIL trap0_ignore valid=%b cyc=%0d ins=%0d code=%h exp=%b/%0d/%0d/%h", cmt_valid, cycle_cnt, instr_cnt, trap_code, e.valid, e.cycle, e.instr, e.code);
      end
   endtask

   task automatic test_trap_lane1();
      do_reset();
      step(2'b11, 64'h8000_0200, 64'h8000_0204, NOP, TRAP, 2'b00, 8'h5a);
      e = sb.pop_front();
      checks++; if (cmt_valid !== e.valid || trap_valid !== e.tv || timeout !== e.to) begin failures++; $display("FAIL trap1_valid valid=%b tv=%b to=%b exp=%b/%b/%b", cmt_valid, trap_valid, timeout, e.valid, e.tv, e.to); end
      checks++; if (trap_code !== e.code || trap_pc !== e.tpc || instr_cnt !== e.instr) begin
         failures++; $display("FAIL trap1_info code=%h pc=%h ins=%0d exp=%h/%h/%0d", trap_code, trap_pc, instr_cnt, e.code, e.tpc, e.instr);
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_dual_commit();
      test_hole();
      test_mmio();
      test_reset_mid();
      test_timeout();
      test_trap_lane0();
      test_trap_lane1();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
